// File: rtl/sound_event_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sound_event_scheduler
//
// Purpose:
//   Shares one speaker pin between four game sound events: two paddle hits
//   (hit1, hit2) and two lost points (miss1, miss2).
//   - One-shot requests are latched into pending bits.
//   - A fixed-priority arbiter grants one source at a time
//     (miss1 > miss2 > hit1 > hit2).
//   - Each grant plays one square-wave tone of a source-specific pitch and
//     length, followed by a fixed silent gap.
//   - There is no preemption: a higher-priority request waits for the current
//     tone and its gap to finish.
//
// Ports:
//   Clock      in   1  system clock
//   Reset      in   1  asynchronous active-low reset
//   hit1       in   1  request pulse, paddle 1 hit
//   hit2       in   1  request pulse, paddle 2 hit
//   miss1      in   1  request pulse, player 1 lost a point
//   miss2      in   1  request pulse, player 2 lost a point
//   mute       in   1  1 = silence output and discard all requests
//   Speaker    out  1  square-wave tone output
//   busy       out  1  1 while a tone or its trailing gap is in progress
//   playing_id out  2  current/last grant: 0=miss1 1=miss2 2=hit1 3=hit2
// -----------------------------------------------------------------------------
module sound_event_scheduler #(
  parameter int unsigned HIT1_HALF = 56818,
  parameter int unsigned HIT2_HALF = 75843,
  parameter int unsigned MISS_HALF = 227272,
  parameter int unsigned HIT_DUR   = 10000000,
  parameter int unsigned MISS_DUR  = 50000000,
  parameter int unsigned GAP       = 2000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       hit1,
  input  logic       hit2,
  input  logic       miss1,
  input  logic       miss2,
  input  logic       mute,
  output logic       Speaker,
  output logic       busy,
  output logic [1:0] playing_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Counters are loaded with (value - 1) so that a count of 0 marks the last
  // cycle of the interval.
  localparam logic [25:0] HIT1_HALF_M1 = 26'(HIT1_HALF - 1);
  localparam logic [25:0] HIT2_HALF_M1 = 26'(HIT2_HALF - 1);
  localparam logic [25:0] MISS_HALF_M1 = 26'(MISS_HALF - 1);
  localparam logic [25:0] HIT_DUR_M1   = 26'(HIT_DUR - 1);
  localparam logic [25:0] MISS_DUR_M1  = 26'(MISS_DUR - 1);
  localparam logic [25:0] GAP_M1       = 26'(GAP - 1);

  // Source index doubles as priority rank: lower index wins.
  function automatic logic [25:0] half_reload(input logic [1:0] id);
    logic [25:0] r;
    case (id)
      2'd2:    r = HIT1_HALF_M1;
      2'd3:    r = HIT2_HALF_M1;
      default: r = MISS_HALF_M1;
    endcase
    return r;
  endfunction

  function automatic logic [25:0] dur_reload(input logic [1:0] id);
    logic [25:0] r;
    if (id[1]) r = HIT_DUR_M1;
    else       r = MISS_DUR_M1;
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [25:0] half_cnt_q, half_cnt_d;
  logic [25:0] dur_cnt_q, dur_cnt_d;
  logic [25:0] gap_cnt_q, gap_cnt_d;
  logic        speaker_q, speaker_d;
  logic        busy_q, busy_d;
  logic [1:0]  id_q, id_d;

  logic [3:0]  req;
  logic [1:0]  win_id;
  logic [3:0]  grant_clr;

  assign req = {hit2, hit1, miss2, miss1};

  // Fixed-priority pick over the registered pending bits only, so a pulse
  // becomes eligible one edge after it is captured.
  always_comb begin
    win_id = 2'd3;
    if      (pending_q[0]) win_id = 2'd0;
    else if (pending_q[1]) win_id = 2'd1;
    else if (pending_q[2]) win_id = 2'd2;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= 4'b0;
      half_cnt_q <= 26'd0;
      dur_cnt_q  <= 26'd0;
      gap_cnt_q  <= 26'd0;
      speaker_q  <= 1'b0;
      busy_q     <= 1'b0;
      id_q       <= 2'd0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      half_cnt_q <= half_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      speaker_q  <= speaker_d;
      busy_q     <= busy_d;
      id_q       <= id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    half_cnt_d = half_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    speaker_d  = speaker_q;
    busy_d     = busy_q;
    id_d       = id_q;
    grant_clr  = 4'b0;

    if (mute) begin
      // Mute drops everything, including requests arriving this cycle;
      // playing_id intentionally keeps the last grant.
      state_d   = ST_IDLE;
      speaker_d = 1'b0;
      busy_d    = 1'b0;
      pending_d = 4'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending_q != 4'b0) begin
            grant_clr  = 4'b0001 << win_id;
            id_d       = win_id;
            half_cnt_d = half_reload(win_id);
            dur_cnt_d  = dur_reload(win_id);
            busy_d     = 1'b1;
            speaker_d  = 1'b0;
            state_d    = ST_TONE;
          end
        end
        ST_TONE: begin
          if (dur_cnt_q == 26'd0) begin
            // Last tone cycle: force silence even if a toggle was due.
            speaker_d = 1'b0;
            gap_cnt_d = GAP_M1;
            state_d   = ST_GAP;
          end else begin
            dur_cnt_d = dur_cnt_q - 26'd1;
            if (half_cnt_q == 26'd0) begin
              half_cnt_d = half_reload(id_q);
              speaker_d  = ~speaker_q;
            end else begin
              half_cnt_d = half_cnt_q - 26'd1;
            end
          end
        end
        ST_GAP: begin
          speaker_d = 1'b0;
          if (gap_cnt_q == 26'd0) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q - 26'd1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          speaker_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
      // Capture after clearing the granted bit: a new pulse on the winner in
      // the same cycle survives and queues a replay.
      pending_d = (pending_q & ~grant_clr) | req;
    end
  end

  assign Speaker    = speaker_q;
  assign busy       = busy_q;
  assign playing_id = id_q;

endmodule

// File: tb/tb_sound_event_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sound_event_scheduler
//
// Purpose:
//   Self-checking bench for sound_event_scheduler with short tone parameters.
//   - Directed per-cycle vector tables cover the main scenarios.
//   - A hand-written sequence checks the asynchronous reset.
//   - A randomized run is compared against a grant-time based reference model.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_sound_event_scheduler;

  localparam int HIT1_HALF = 2;
  localparam int HIT2_HALF = 3;
  localparam int MISS_HALF = 5;
  localparam int HIT_DUR   = 12;
  localparam int MISS_DUR  = 20;
  localparam int GAP       = 4;

  logic       Clock;
  logic       Reset;
  logic       hit1, hit2, miss1, miss2, mute;
  logic       Speaker;
  logic       busy;
  logic [1:0] playing_id;

  int tests_run = 0;
  int tests_failed = 0;

  sound_event_scheduler #(
    .HIT1_HALF(HIT1_HALF), .HIT2_HALF(HIT2_HALF), .MISS_HALF(MISS_HALF),
    .HIT_DUR(HIT_DUR), .MISS_DUR(MISS_DUR), .GAP(GAP)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .hit1(hit1), .hit2(hit2), .miss1(miss1), .miss2(miss2), .mute(mute),
    .Speaker(Speaker), .busy(busy), .playing_id(playing_id)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Request bit order: [0]=miss1 [1]=miss2 [2]=hit1 [3]=hit2
  typedef struct {
    logic [3:0] req;   // pulsed on the first cycle of the row only
    logic       mute;  // held for every cycle of the row
    int         n;     // cycles covered by the row
    logic       spk;
    logic       busy;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] r, input logic m, input int n,
                              input logic s, input logic b, input logic [1:0] id);
    vec_t v;
    v.req = r; v.mute = m; v.n = n; v.spk = s; v.busy = b; v.id = id;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [3:0] r, input logic m);
    miss1 = r[0]; miss2 = r[1]; hit1 = r[2]; hit2 = r[3]; mute = m;
  endtask

  task automatic check(input string name, input logic s, input logic b,
                       input logic [1:0] id);
    tests_run++;
    if (Speaker !== s || busy !== b || playing_id !== id) begin
      tests_failed++;
      $display("FAIL %s: got spk=%0b busy=%0b id=%0d, expected spk=%0b busy=%0b id=%0d",
               name, Speaker, busy, playing_id, s, b, id);
    end
  endtask

  // Reference model: remembers the grant cycle and source; outputs follow
  // from the cycle offset since the grant.
  int         m_cyc, m_g, m_src;
  bit         m_active;
  logic [3:0] m_pend;
  logic [1:0] m_id;

  function automatic int dur_of(input int s);
    return (s < 2) ? MISS_DUR : HIT_DUR;
  endfunction

  function automatic int half_of(input int s);
    return (s < 2) ? MISS_HALF : ((s == 2) ? HIT1_HALF : HIT2_HALF);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_g = 0; m_src = 0; m_active = 0; m_pend = 4'b0; m_id = 2'd0;
  endtask

  // One clock edge with the given inputs.
  task automatic model_step(input logic [3:0] r, input logic m);
    int w;
    m_cyc++;
    if (m) begin
      m_active = 0;
      m_pend   = 4'b0;
    end else begin
      // Idle before this edge if no grant yet, or tone+gap already elapsed.
      if ((!m_active || (m_cyc - 1 - m_g) >= dur_of(m_src) + GAP) && m_pend != 4'b0) begin
        w = 0;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) w = i;
        m_pend[w] = 1'b0;
        m_g = m_cyc; m_src = w; m_active = 1; m_id = 2'(w);
      end
      m_pend = m_pend | r;
    end
  endtask

  task automatic model_outputs(output logic s, output logic b);
    int k;
    s = 1'b0; b = 1'b0;
    if (m_active) begin
      k = m_cyc - m_g;
      if (k < dur_of(m_src)) s = ((k / half_of(m_src)) % 2) == 1;
      b = (k < dur_of(m_src) + GAP);
    end
  endtask

  initial begin
    logic es, eb;
    logic [3:0] r;
    logic m;

    Reset = 1'b0;
    drive(4'b0, 1'b0);
    repeat (2) @(negedge Clock);
    check("reset_state", 1'b0, 1'b0, 2'd0);
    Reset = 1'b1;

    // hit1 alone: half 2, 12-cycle tone, 4-cycle gap
    add(4'b0100, 0, 1, 0, 0, 2'd0);
    add(4'b0000, 0, 2, 0, 1, 2'd2); add(4'b0000, 0, 2, 1, 1, 2'd2);
    add(4'b0000, 0, 2, 0, 1, 2'd2); add(4'b0000, 0, 2, 1, 1, 2'd2);
    add(4'b0000, 0, 2, 0, 1, 2'd2); add(4'b0000, 0, 2, 1, 1, 2'd2);
    add(4'b0000, 0, 4, 0, 1, 2'd2); add(4'b0000, 0, 3, 0, 0, 2'd2);
    // hit2 + miss2 together: miss2 first, hit2 after GAP+1 silent cycles
    add(4'b1010, 0, 1, 0, 0, 2'd2);
    add(4'b0000, 0, 5, 0, 1, 2'd1); add(4'b0000, 0, 5, 1, 1, 2'd1);
    add(4'b0000, 0, 5, 0, 1, 2'd1); add(4'b0000, 0, 5, 1, 1, 2'd1);
    add(4'b0000, 0, 4, 0, 1, 2'd1); add(4'b0000, 0, 1, 0, 0, 2'd1);
    add(4'b0000, 0, 3, 0, 1, 2'd3); add(4'b0000, 0, 3, 1, 1, 2'd3);
    add(4'b0000, 0, 3, 0, 1, 2'd3); add(4'b0000, 0, 3, 1, 1, 2'd3);
    add(4'b0000, 0, 4, 0, 1, 2'd3); add(4'b0000, 0, 2, 0, 0, 2'd3);
    // miss1 during hit2 tone: no preemption
    add(4'b1000, 0, 1, 0, 0, 2'd3);
    add(4'b0000, 0, 3, 0, 1, 2'd3); add(4'b0001, 0, 3, 1, 1, 2'd3);
    add(4'b0000, 0, 3, 0, 1, 2'd3); add(4'b0000, 0, 3, 1, 1, 2'd3);
    add(4'b0000, 0, 4, 0, 1, 2'd3); add(4'b0000, 0, 1, 0, 0, 2'd3);
    add(4'b0000, 0, 5, 0, 1, 2'd0); add(4'b0000, 0, 5, 1, 1, 2'd0);
    add(4'b0000, 0, 5, 0, 1, 2'd0); add(4'b0000, 0, 5, 1, 1, 2'd0);
    add(4'b0000, 0, 4, 0, 1, 2'd0); add(4'b0000, 0, 2, 0, 0, 2'd0);
    // hit1 pulsed three times during its own tone: exactly one replay
    add(4'b0100, 0, 1, 0, 0, 2'd0);
    add(4'b0000, 0, 2, 0, 1, 2'd2); add(4'b0100, 0, 2, 1, 1, 2'd2);
    add(4'b0100, 0, 2, 0, 1, 2'd2); add(4'b0100, 0, 2, 1, 1, 2'd2);
    add(4'b0000, 0, 2, 0, 1, 2'd2); add(4'b0000, 0, 2, 1, 1, 2'd2);
    add(4'b0000, 0, 4, 0, 1, 2'd2); add(4'b0000, 0, 1, 0, 0, 2'd2);
    add(4'b0000, 0, 2, 0, 1, 2'd2); add(4'b0000, 0, 2, 1, 1, 2'd2);
    add(4'b0000, 0, 2, 0, 1, 2'd2); add(4'b0000, 0, 2, 1, 1, 2'd2);
    add(4'b0000, 0, 2, 0, 1, 2'd2); add(4'b0000, 0, 2, 1, 1, 2'd2);
    add(4'b0000, 0, 4, 0, 1, 2'd2); add(4'b0000, 0, 4, 0, 0, 2'd2);
    // mute mid-tone with hit2 pending, then a request dropped under mute
    add(4'b1000, 0, 1, 0, 0, 2'd2);
    add(4'b0000, 0, 2, 0, 1, 2'd3); add(4'b1000, 0, 1, 0, 1, 2'd3);
    add(4'b0000, 0, 1, 1, 1, 2'd3); add(4'b0000, 1, 1, 0, 0, 2'd3);
    add(4'b0100, 1, 1, 0, 0, 2'd3); add(4'b0000, 0, 6, 0, 0, 2'd3);

    foreach (vecs[v]) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        drive((c == 0) ? vecs[v].req : 4'b0, vecs[v].mute);
        @(posedge Clock);
        @(negedge Clock);
        check($sformatf("row%0d_cyc%0d", v, c), vecs[v].spk, vecs[v].busy, vecs[v].id);
      end
      $display("[TB] row %0d req=%b mute=%0b cycles=%0d checked", v, vecs[v].req,
               vecs[v].mute, vecs[v].n);
    end
    drive(4'b0, 1'b0);

    // Asynchronous reset in the middle of a hit1 tone with hit2 pending
    drive(4'b0100, 1'b0);
    @(negedge Clock); drive(4'b1000, 1'b0);
    @(negedge Clock); drive(4'b0000, 1'b0);
    @(negedge Clock);
    @(negedge Clock);
    check("pre_reset_tone", 1'b1, 1'b1, 2'd2);
    #2 Reset = 1'b0;
    #1 check("async_reset", 1'b0, 1'b0, 2'd0);
    @(negedge Clock); Reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      check($sformatf("post_reset_idle%0d", c), 1'b0, 1'b0, 2'd0);
    end
    $display("[TB] async reset sequence checked");

    // Randomized run against the reference model
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    model_reset();
    for (int c = 0; c < 800; c++) begin
      r = 4'b0;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 19) == 0);
      m = ($urandom_range(0, 59) == 0);
      drive(r, m);
      model_step(r, m);
      @(posedge Clock);
      @(negedge Clock);
      model_outputs(es, eb);
      check($sformatf("rand_cyc%0d", c), es, eb, m_id);
    end
    drive(4'b0, 1'b0);
    $display("[TB] random run of 800 cycles checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
